// File: rtl/rom_arb_pkg.sv
// Shared types for the ROM upload arbiter: queued SDRAM write entries,
// byte-enable encodings and issuer states.
package rom_arb_pkg;

    localparam int WR_ADDR_W = 22;

    localparam logic [1:0] DS_LO   = 2'b01;
    localparam logic [1:0] DS_HI   = 2'b10;
    localparam logic [1:0] DS_BOTH = 2'b11;

    typedef struct packed {
        logic [WR_ADDR_W-1:0] addr;
        logic [1:0]           ds;
        logic [15:0]          data;
    } wr_entry_t;

    typedef enum logic {ST_IDLE, ST_WAIT} arb_state_t;

    // Unused byte lanes of an entry are always zero, so both lanes can be summed blindly.
    function automatic logic [8:0] entry_byte_sum(input wr_entry_t e);
        return {1'b0, e.data[15:8]} + {1'b0, e.data[7:0]};
    endfunction

endpackage

// File: rtl/rom_arb_fifo.sv
// Synchronous write-entry queue; a push into a full queue is accepted when a pop
// happens in the same cycle.
module rom_arb_fifo
    import rom_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_sys,
    input  logic      reset_n,
    input  logic      push,
    input  wr_entry_t push_data,
    input  logic      pop,
    output wr_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    wr_entry_t     mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; the count guards it, and leaving it unreset keeps it RAM-mappable.
    always_ff @(posedge clk_sys) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/rom_upload_arbiter.sv
// Packs ioctl ROM bytes into 16-bit SDRAM port-1 writes and parks the CPU port during download.
// Optional feature macro ROM_CHECKSUM_EN adds a running byte checksum output.
module rom_upload_arbiter
    import rom_arb_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 4,
    parameter int          ADDR_W      = WR_ADDR_W,
    parameter logic [16:0] PARK_ADDR   = 17'h1ffff,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [ADDR_W:0]   dl_addr,
    input  logic [7:0]        dl_data,
    output logic              sd_req,
    input  logic              sd_ack,
    output logic [ADDR_W-1:0] sd_addr,
    output logic [1:0]        sd_ds,
    output logic [15:0]       sd_d,
    output logic              sd_we,
    input  logic [14:0]       cpu_addr,
    output logic [7:0]        cpu_data,
    output logic [16:0]       sd_cpu_addr,
    input  logic [15:0]       sd_cpu_q,
    output logic              busy,
    output logic              done,
    output logic              err_ovf,
    output logic              err_tmo
`ifdef ROM_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    arb_state_t           state;
    logic [TMO_W-1:0]     tmo_cnt;
    logic                 dl_active_q;
    logic                 flush_q;
    logic                 pend_valid;
    logic                 pend_lane;
    logic [WR_ADDR_W-1:0] pend_word;
    logic [7:0]           pend_data;

    logic                 rise;
    logic                 wr_ok;
    logic                 pair;
    logic [WR_ADDR_W-1:0] word_new;
    logic                 push;
    wr_entry_t            push_entry;
    wr_entry_t            pend_entry;
    wr_entry_t            head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic                 tmo_hit;
    logic                 drop;
    logic                 busy_clear;

    assign rise     = dl_active && !dl_active_q;
    // Bytes strobed on the cycle dl_active drops still belong to the download.
    assign wr_ok    = dl_wr && (dl_active || dl_active_q);
    assign word_new = WR_ADDR_W'(dl_addr[ADDR_W:1]);
    assign pair     = pend_valid && !pend_lane && dl_addr[0] && (word_new == pend_word);
    assign tmo_hit  = (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1));
    assign pop      = (state == ST_WAIT) && ((sd_ack == sd_req) || tmo_hit);
    assign drop     = push && fifo_full && !pop;

    assign busy_clear = busy && !dl_active && !dl_active_q && !flush_q && !pend_valid
                      && fifo_empty && (state == ST_IDLE);

    assign sd_we       = busy;
    assign sd_cpu_addr = busy ? PARK_ADDR : {3'b000, cpu_addr[14:1]};
    assign cpu_data    = cpu_addr[0] ? sd_cpu_q[15:8] : sd_cpu_q[7:0];

    // NOTE: every combinationally driven signal gets a default first so no latch is inferred.
    always_comb begin
        pend_entry.addr = pend_word;
        pend_entry.ds   = pend_lane ? DS_HI : DS_LO;
        pend_entry.data = pend_lane ? {pend_data, 8'h00} : {8'h00, pend_data};
        push            = 1'b0;
        push_entry      = pend_entry;
        if (wr_ok && pair) begin
            push            = 1'b1;
            push_entry.ds   = DS_BOTH;
            push_entry.data = {dl_data, pend_data};
        end else if ((wr_ok || flush_q) && pend_valid) begin
            push = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_active_q <= 1'b0;
            flush_q     <= 1'b0;
            pend_valid  <= 1'b0;
            pend_lane   <= 1'b0;
            pend_word   <= '0;
            pend_data   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_ovf     <= 1'b0;
        end else begin
            dl_active_q <= dl_active;
            flush_q     <= dl_active_q && !dl_active;
            done        <= 1'b0;
            if (wr_ok) begin
                pend_valid <= !pair;
                pend_lane  <= dl_addr[0];
                pend_word  <= word_new;
                pend_data  <= dl_data;
            end else if (flush_q) begin
                pend_valid <= 1'b0;
            end
            if (rise) begin
                busy    <= 1'b1;
                err_ovf <= 1'b0;
            end else begin
                if (drop) err_ovf <= 1'b1;
                if (busy_clear) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    rom_arb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The head stays queued while in flight so sd_addr/ds/d remain stable through WAIT.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            sd_req  <= 1'b0;
            sd_addr <= '0;
            sd_ds   <= '0;
            sd_d    <= '0;
            tmo_cnt <= '0;
            err_tmo <= 1'b0;
        end else begin
            if (rise) err_tmo <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        sd_addr <= ADDR_W'(head.addr);
                        sd_ds   <= head.ds;
                        sd_d    <= head.data;
                        sd_req  <= !sd_req;
                        tmo_cnt <= '0;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (sd_ack == sd_req) begin
                        state <= ST_IDLE;
                    end else if (tmo_hit) begin
                        err_tmo <= 1'b1;
                        sd_req  <= sd_ack;
                        state   <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ROM_CHECKSUM_EN
    // Bytes are counted when strobed and backed out again if their entry is later dropped.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            checksum <= '0;
        end else if (rise) begin
            checksum <= '0;
        end else if (busy) begin
            checksum <= checksum + (wr_ok ? {8'h00, dl_data} : 16'h0000)
                                 - (drop ? {7'h00, entry_byte_sum(push_entry)} : 16'h0000);
        end
    end
`endif

endmodule

// File: tb/tb_rom_upload_arbiter.sv
// Directed self-checking bench for rom_upload_arbiter; ack responder and write monitor run on negedge.
module tb_rom_upload_arbiter;

    localparam int ADDR_W = 22;

    logic              clk_sys = 1'b0;
    logic              reset_n = 1'b0;
    logic              dl_active = 1'b0;
    logic              dl_wr = 1'b0;
    logic [ADDR_W:0]   dl_addr = '0;
    logic [7:0]        dl_data = '0;
    logic              sd_req;
    logic              sd_ack = 1'b0;
    logic [ADDR_W-1:0] sd_addr;
    logic [1:0]        sd_ds;
    logic [15:0]       sd_d;
    logic              sd_we;
    logic [14:0]       cpu_addr = '0;
    logic [7:0]        cpu_data;
    logic [16:0]       sd_cpu_addr;
    logic [15:0]       sd_cpu_q = '0;
    logic              busy;
    logic              done;
    logic              err_ovf;
    logic              err_tmo;
`ifdef ROM_CHECKSUM_EN
    logic [15:0]       checksum;
`endif

    int checks = 0;
    int failures = 0;

    logic              ack_en = 1'b0;
    int                ack_dly = 0;
    logic              mon_last = 1'b0;
    int                n_wr = 0;
    logic [31:0]       mon_addr [64];
    logic [31:0]       mon_ds   [64];
    logic [31:0]       mon_d    [64];

    rom_upload_arbiter dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .dl_active   (dl_active),
        .dl_wr       (dl_wr),
        .dl_addr     (dl_addr),
        .dl_data     (dl_data),
        .sd_req      (sd_req),
        .sd_ack      (sd_ack),
        .sd_addr     (sd_addr),
        .sd_ds       (sd_ds),
        .sd_d        (sd_d),
        .sd_we       (sd_we),
        .cpu_addr    (cpu_addr),
        .cpu_data    (cpu_data),
        .sd_cpu_addr (sd_cpu_addr),
        .sd_cpu_q    (sd_cpu_q),
        .busy        (busy),
        .done        (done),
        .err_ovf     (err_ovf),
        .err_tmo     (err_tmo)
`ifdef ROM_CHECKSUM_EN
        ,
        .checksum    (checksum)
`endif
    );

    always #20 clk_sys = ~clk_sys;

    // Logs each new request (req toggled away from ack) and echoes ack two cycles later when enabled.
    always @(negedge clk_sys) begin
        if (!reset_n) begin
            sd_ack   = 1'b0;
            ack_dly  = 0;
            mon_last = 1'b0;
        end else begin
            if (sd_req !== mon_last) begin
                if (sd_req !== sd_ack && n_wr < 64) begin
                    mon_addr[n_wr] = 32'(sd_addr);
                    mon_ds[n_wr]   = 32'(sd_ds);
                    mon_d[n_wr]    = 32'(sd_d);
                    n_wr++;
                end
                mon_last = sd_req;
            end
            if (ack_en && sd_req !== sd_ack) begin
                ack_dly++;
                if (ack_dly >= 2) begin
                    sd_ack  = sd_req;
                    ack_dly = 0;
                end
            end else begin
                ack_dly = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic wr_byte(input logic [ADDR_W:0] a, input logic [7:0] d);
        dl_addr = a;
        dl_data = d;
        dl_wr   = 1'b1;
        tick(1);
        dl_wr   = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 600; i++) begin
            tick(1);
            if (!busy) break;
        end
        check({tag, "_busy_fall"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic check_wr(input string tag, input int idx, input logic [31:0] a,
                            input logic [31:0] ds, input logic [31:0] d);
        if (idx < 0 || idx >= n_wr) begin
            check({tag, "_present"}, 32'(n_wr), 32'(idx + 1));
        end else begin
            check({tag, "_addr"}, mon_addr[idx], a);
            check({tag, "_ds"}, mon_ds[idx], ds);
            check({tag, "_d"}, mon_d[idx], d);
        end
    endtask

    initial begin
        int base;
        int cyc;

        tick(3);
        check("rst_sd_req", 32'(sd_req), 32'd0);
        check("rst_busy_in_reset", 32'(busy), 32'd0);
        reset_n = 1'b1;
        tick(2);
        check("rst_sd_addr", 32'(sd_addr), 32'd0);
        check("rst_sd_ds", 32'(sd_ds), 32'd0);
        check("rst_sd_d", 32'(sd_d), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", {30'd0, err_ovf, err_tmo}, 32'd0);
        check("rst_we", 32'(sd_we), 32'd0);

        // 1: paired bytes become one full-word write
        ack_en    = 1'b1;
        dl_active = 1'b1;
        tick(1);
        check("t1_busy_set", 32'(busy), 32'd1);
        check("t1_we", 32'(sd_we), 32'd1);
        check("t1_park", 32'(sd_cpu_addr), 32'h1ffff);
        base = n_wr;
        wr_byte(23'd0, 8'h11);
        wr_byte(23'd1, 8'h22);
        tick(8);
        dl_active = 1'b0;
        wait_idle("t1");
        check("t1_count", 32'(n_wr), 32'(base + 1));
        check_wr("t1_wr", base, 32'd0, 32'h3, 32'h2211);
        tick(1);
        check("t1_done_pulse_end", 32'(done), 32'd0);

        // 2: lone odd byte then lone even byte, each flushed at download end
        dl_active = 1'b1;
        tick(2);
        base = n_wr;
        wr_byte(23'd3, 8'h5A);
        dl_active = 1'b0;
        wait_idle("t2a");
        check_wr("t2a_wr", base, 32'd1, 32'h2, 32'h5A00);
        dl_active = 1'b1;
        tick(2);
        wr_byte(23'd4, 8'h33);
        dl_active = 1'b0;
        wait_idle("t2b");
        check_wr("t2b_wr", base + 1, 32'd2, 32'h1, 32'h0033);
        check("t2_count", 32'(n_wr), 32'(base + 2));
        check("t2_no_ovf", 32'(err_ovf), 32'd0);

        // 3: stuck ack times out, next entry issued with req resynchronised
        ack_en    = 1'b0;
        dl_active = 1'b1;
        tick(2);
        base = n_wr;
        wr_byte(23'd0, 8'hA1);
        wr_byte(23'd1, 8'hA2);
        wr_byte(23'd2, 8'hB1);
        wr_byte(23'd3, 8'hB2);
        cyc = 0;
        while (!err_tmo && cyc < 400) begin
            tick(1);
            cyc++;
        end
        check("t3_err_tmo", 32'(err_tmo), 32'd1);
        check("t3_tmo_window", 32'(cyc >= 245 && cyc <= 260), 32'd1);
        for (int i = 0; i < 10 && n_wr < base + 2; i++) tick(1);
        check("t3_count", 32'(n_wr), 32'(base + 2));
        check_wr("t3_first", base, 32'd0, 32'h3, 32'hA2A1);
        check_wr("t3_second", base + 1, 32'd1, 32'h3, 32'hB2B1);
        check("t3_req_pending", 32'(sd_req ^ sd_ack), 32'd1);
        ack_en    = 1'b1;
        dl_active = 1'b0;
        wait_idle("t3");
        check("t3_tmo_sticky", 32'(err_tmo), 32'd1);

        // 4: ack withheld while six unpaired bytes arrive; one is dropped
        ack_en    = 1'b0;
        dl_active = 1'b1;
        tick(1);
        check("t4_tmo_cleared", 32'(err_tmo), 32'd0);
        base = n_wr;
        for (int i = 0; i < 6; i++) wr_byte(23'(2 * i), 8'(i + 1));
        tick(2);
        check("t4_err_ovf", 32'(err_ovf), 32'd1);
        check("t4_one_in_flight", 32'(n_wr), 32'(base + 1));
        ack_en = 1'b1;
        tick(30);
        dl_active = 1'b0;
        wait_idle("t4");
        check("t4_count", 32'(n_wr), 32'(base + 5));
        check_wr("t4_w0", base, 32'd0, 32'h1, 32'h0001);
        check_wr("t4_w3", base + 3, 32'd3, 32'h1, 32'h0004);
        check_wr("t4_w4", base + 4, 32'd5, 32'h1, 32'h0006);

        // 5: CPU port pass-through when idle
        cpu_addr = 15'h0003;
        sd_cpu_q = 16'hBEEF;
        #1;
        check("t5_cpu_addr", 32'(sd_cpu_addr), 32'h1);
        check("t5_cpu_hi", 32'(cpu_data), 32'hBE);
        cpu_addr = 15'h7ffe;
        #1;
        check("t5_cpu_addr_top", 32'(sd_cpu_addr), 32'h3fff);
        check("t5_cpu_lo", 32'(cpu_data), 32'hEF);

        // 6: reset while WAITing, then a clean restart
        ack_en    = 1'b0;
        dl_active = 1'b1;
        tick(1);
        check("t6_ovf_cleared", 32'(err_ovf), 32'd0);
        wr_byte(23'd0, 8'h11);
        wr_byte(23'd1, 8'h22);
        tick(3);
        check("t6_in_wait", 32'(sd_req ^ sd_ack), 32'd1);
        reset_n   = 1'b0;
        dl_active = 1'b0;
        #1;
        check("t6_rst_req", 32'(sd_req), 32'd0);
        check("t6_rst_addr", 32'(sd_addr), 32'd0);
        check("t6_rst_ds", 32'(sd_ds), 32'd0);
        check("t6_rst_d", 32'(sd_d), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        check("t6_rst_err", {30'd0, err_ovf, err_tmo}, 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(2);
        ack_en    = 1'b1;
        dl_active = 1'b1;
        tick(1);
        base = n_wr;
        wr_byte(23'd0, 8'hFF);
        wr_byte(23'd1, 8'h02);
        tick(6);
        dl_active = 1'b0;
        wait_idle("t6");
        check("t6_count", 32'(n_wr), 32'(base + 1));
        check_wr("t6_wr", base, 32'd0, 32'h3, 32'h02FF);
`ifdef ROM_CHECKSUM_EN
        check("t6_checksum", 32'(checksum), 32'h0101);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
